// File: rtl/burst_ram_arbiter_pkg.sv
// Shared definitions for the two-port BurstRAM arbiter: command encodings and
// the arbiter state type.
package burst_ram_arbiter_pkg;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WRITE_DATA,
      ST_READ_WAIT,
      ST_RELEASE
   } arb_state_e;

endpackage

// File: rtl/burst_ram_arbiter_port.sv
// One requester's capture buffer: holds a full command (all write words and masks)
// until the arbiter has replayed it to the RAM and released the port.
module burst_ram_arbiter_port
   import burst_ram_arbiter_pkg::*;
#(
   parameter int PORT_ID        = 0,
   parameter int DEPTH_BITWIDTH = 4,
   parameter int DATA_BITWIDTH  = 64,
   parameter int BURST_COUNT    = 4
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         i_cmd,
   input  logic                                         i_cmd_en,
   input  logic [DEPTH_BITWIDTH-1:0]                    i_addr,
   input  logic [DATA_BITWIDTH-1:0]                     i_wr_data,
   input  logic [DATA_BITWIDTH/8-1:0]                   i_data_mask,
   input  logic                                         i_done,
   input  logic                                         i_release,
   output logic                                         o_cmd,
   output logic [DEPTH_BITWIDTH-1:0]                    o_addr,
   output logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0]    o_words,
   output logic [BURST_COUNT-1:0][DATA_BITWIDTH/8-1:0]  o_masks,
   output logic                                         o_pending,
   output logic                                         o_busy
);
   localparam int CNT_W = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;

   logic                                         r_cmd;
   logic [DEPTH_BITWIDTH-1:0]                    r_addr;
   logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0]    r_words;
   logic [BURST_COUNT-1:0][DATA_BITWIDTH/8-1:0]  r_masks;
   logic                                         r_pending;
   logic                                         r_busy;
   logic                                         r_active;
   logic                                         r_capturing;
   logic [CNT_W-1:0]                             r_cap_cnt;
   logic                                         w_accept;

   assign w_accept = i_cmd_en && !r_busy;

   // r_active tracks an outstanding command; busy comes out of reset high and
   // drops on the first edge because nothing is active yet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd       <= CMD_READ;
         r_addr      <= '0;
         r_words     <= '0;
         r_masks     <= '0;
         r_pending   <= 1'b0;
         r_busy      <= 1'b1;
         r_active    <= 1'b0;
         r_capturing <= 1'b0;
         r_cap_cnt   <= '0;
      end else begin
         r_busy <= w_accept || (r_active && !i_release);
         if (w_accept) begin
            r_active   <= 1'b1;
            r_cmd      <= i_cmd;
            r_addr     <= i_addr;
            r_words[0] <= i_wr_data;
            r_masks[0] <= i_data_mask;
            if (i_cmd == CMD_WRITE && BURST_COUNT > 1) begin
               r_capturing <= 1'b1;
               r_cap_cnt   <= CNT_W'(1);
            end else begin
               r_pending <= 1'b1;
            end
         end else if (r_capturing) begin
            r_words[r_cap_cnt] <= i_wr_data;
            r_masks[r_cap_cnt] <= i_data_mask;
            if (r_cap_cnt == CNT_W'(BURST_COUNT - 1)) begin
               r_capturing <= 1'b0;
               r_cap_cnt   <= '0;
               r_pending   <= 1'b1;
            end else begin
               r_cap_cnt <= r_cap_cnt + 1'b1;
            end
         end
         if (i_done) begin
            r_pending <= 1'b0;
         end
         if (i_release) begin
            r_active <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(i_cmd_en && r_busy))
            else $warning("port %0d: cmd_en while busy, command ignored", PORT_ID);
      end
   end

   assign o_cmd     = r_cmd;
   assign o_addr    = r_addr;
   assign o_words   = r_words;
   assign o_masks   = r_masks;
   assign o_pending = r_pending;
   assign o_busy    = r_busy;

endmodule

// File: rtl/burst_ram_arbiter.sv
// Lets an instruction cache (port 0) and a data cache (port 1) share one BurstRAM,
// replaying whole buffered bursts to the RAM in round-robin order.
module burst_ram_arbiter
   import burst_ram_arbiter_pkg::*;
#(
   parameter int DEPTH_BITWIDTH = 4,
   parameter int DATA_BITWIDTH  = 64,
   parameter int BURST_COUNT    = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        p0_cmd,
   input  logic                        p0_cmd_en,
   input  logic [DEPTH_BITWIDTH-1:0]   p0_addr,
   input  logic [DATA_BITWIDTH-1:0]    p0_wr_data,
   input  logic [DATA_BITWIDTH/8-1:0]  p0_data_mask,
   output logic [DATA_BITWIDTH-1:0]    p0_rd_data,
   output logic                        p0_rd_data_valid,
   output logic                        p0_busy,
   input  logic                        p1_cmd,
   input  logic                        p1_cmd_en,
   input  logic [DEPTH_BITWIDTH-1:0]   p1_addr,
   input  logic [DATA_BITWIDTH-1:0]    p1_wr_data,
   input  logic [DATA_BITWIDTH/8-1:0]  p1_data_mask,
   output logic [DATA_BITWIDTH-1:0]    p1_rd_data,
   output logic                        p1_rd_data_valid,
   output logic                        p1_busy,
   output logic                        br_cmd,
   output logic                        br_cmd_en,
   output logic [DEPTH_BITWIDTH-1:0]   br_addr,
   output logic [DATA_BITWIDTH-1:0]    br_wr_data,
   output logic [DATA_BITWIDTH/8-1:0]  br_data_mask,
   input  logic [DATA_BITWIDTH-1:0]    br_rd_data,
   input  logic                        br_rd_data_valid,
   input  logic                        br_busy
);
   // state         | meaning
   // ST_IDLE       | waiting for a pending port while the RAM is free
   // ST_ISSUE      | br_cmd_en high with the owner's command, address and word 0
   // ST_WRITE_DATA | streaming write words 1..BURST_COUNT-1
   // ST_READ_WAIT  | routing returned read words to the owner only
   // ST_RELEASE    | waiting for the RAM to go idle before freeing the owner
   localparam int CNT_W  = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
   localparam int MASK_W = DATA_BITWIDTH / 8;

   logic [1:0]                                 w_cmd;
   logic [DEPTH_BITWIDTH-1:0]                  w_addr    [2];
   logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0]  w_words   [2];
   logic [BURST_COUNT-1:0][MASK_W-1:0]         w_masks   [2];
   logic [1:0]                                 w_pending;
   logic [1:0]                                 w_busy;
   logic                                       w_done;
   logic                                       w_release;
   logic                                       w_grant_port;
   logic [CNT_W-1:0]                           w_cnt_inc;

   arb_state_e                  r_state, w_state_nxt;
   logic                        r_owner, w_owner_nxt;
   logic                        r_last_grant, w_last_grant_nxt;
   logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
   logic                        r_br_cmd_en, w_br_cmd_en_nxt;
   logic                        r_br_cmd, w_br_cmd_nxt;
   logic [DEPTH_BITWIDTH-1:0]   r_br_addr, w_br_addr_nxt;
   logic [DATA_BITWIDTH-1:0]    r_br_wr_data, w_br_wr_data_nxt;
   logic [MASK_W-1:0]           r_br_mask, w_br_mask_nxt;

   burst_ram_arbiter_port #(
      .PORT_ID(0), .DEPTH_BITWIDTH(DEPTH_BITWIDTH),
      .DATA_BITWIDTH(DATA_BITWIDTH), .BURST_COUNT(BURST_COUNT)
   ) u_port0 (
      .clk(clk), .rst_n(rst_n),
      .i_cmd(p0_cmd), .i_cmd_en(p0_cmd_en), .i_addr(p0_addr),
      .i_wr_data(p0_wr_data), .i_data_mask(p0_data_mask),
      .i_done(w_done && !r_owner), .i_release(w_release && !r_owner),
      .o_cmd(w_cmd[0]), .o_addr(w_addr[0]), .o_words(w_words[0]), .o_masks(w_masks[0]),
      .o_pending(w_pending[0]), .o_busy(w_busy[0])
   );

   burst_ram_arbiter_port #(
      .PORT_ID(1), .DEPTH_BITWIDTH(DEPTH_BITWIDTH),
      .DATA_BITWIDTH(DATA_BITWIDTH), .BURST_COUNT(BURST_COUNT)
   ) u_port1 (
      .clk(clk), .rst_n(rst_n),
      .i_cmd(p1_cmd), .i_cmd_en(p1_cmd_en), .i_addr(p1_addr),
      .i_wr_data(p1_wr_data), .i_data_mask(p1_data_mask),
      .i_done(w_done && r_owner), .i_release(w_release && r_owner),
      .o_cmd(w_cmd[1]), .o_addr(w_addr[1]), .o_words(w_words[1]), .o_masks(w_masks[1]),
      .o_pending(w_pending[1]), .o_busy(w_busy[1])
   );

   assign w_cnt_inc = r_cnt + 1'b1;

   always_comb begin
      w_state_nxt      = r_state;
      w_owner_nxt      = r_owner;
      w_last_grant_nxt = r_last_grant;
      w_cnt_nxt        = r_cnt;
      w_br_cmd_en_nxt  = 1'b0;
      w_br_cmd_nxt     = r_br_cmd;
      w_br_addr_nxt    = r_br_addr;
      w_br_wr_data_nxt = r_br_wr_data;
      w_br_mask_nxt    = r_br_mask;
      w_done           = 1'b0;
      w_release        = 1'b0;
      w_grant_port     = (&w_pending) ? ~r_last_grant : w_pending[1];
      case (r_state)
         ST_IDLE: begin
            if ((|w_pending) && !br_busy) begin
               w_owner_nxt      = w_grant_port;
               w_last_grant_nxt = w_grant_port;
               w_br_cmd_en_nxt  = 1'b1;
               w_br_cmd_nxt     = w_cmd[w_grant_port];
               w_br_addr_nxt    = w_addr[w_grant_port];
               w_br_wr_data_nxt = w_words[w_grant_port][0];
               w_br_mask_nxt    = w_masks[w_grant_port][0];
               w_state_nxt      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (r_br_cmd == CMD_WRITE) begin
               w_cnt_nxt        = CNT_W'(1);
               w_br_wr_data_nxt = w_words[r_owner][1];
               w_br_mask_nxt    = w_masks[r_owner][1];
               w_state_nxt      = ST_WRITE_DATA;
            end else begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_READ_WAIT;
            end
         end
         ST_WRITE_DATA: begin
            if (r_cnt == CNT_W'(BURST_COUNT - 1)) begin
               w_done      = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_RELEASE;
            end else begin
               w_cnt_nxt        = w_cnt_inc;
               w_br_wr_data_nxt = w_words[r_owner][w_cnt_inc];
               w_br_mask_nxt    = w_masks[r_owner][w_cnt_inc];
            end
         end
         ST_READ_WAIT: begin
            if (br_rd_data_valid) begin
               if (r_cnt == CNT_W'(BURST_COUNT - 1)) begin
                  w_done      = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_RELEASE;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
         end
         ST_RELEASE: begin
            if (!br_busy) begin
               w_release   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // last_grant resets to port 1 so port 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_cnt        <= '0;
         r_br_cmd_en  <= 1'b0;
         r_br_cmd     <= CMD_READ;
         r_br_addr    <= '0;
         r_br_wr_data <= '0;
         r_br_mask    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_cnt        <= w_cnt_nxt;
         r_br_cmd_en  <= w_br_cmd_en_nxt;
         r_br_cmd     <= w_br_cmd_nxt;
         r_br_addr    <= w_br_addr_nxt;
         r_br_wr_data <= w_br_wr_data_nxt;
         r_br_mask    <= w_br_mask_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(br_rd_data_valid && (r_state == ST_IDLE || r_state == ST_WRITE_DATA)))
            else $warning("br_rd_data_valid outside a read burst ignored");
      end
   end

   assign br_cmd_en        = r_br_cmd_en;
   assign br_cmd           = r_br_cmd;
   assign br_addr          = r_br_addr;
   assign br_wr_data       = r_br_wr_data;
   assign br_data_mask     = r_br_mask;
   assign p0_rd_data       = br_rd_data;
   assign p1_rd_data       = br_rd_data;
   assign p0_rd_data_valid = br_rd_data_valid && (r_state == ST_READ_WAIT) && !r_owner;
   assign p1_rd_data_valid = br_rd_data_valid && (r_state == ST_READ_WAIT) && r_owner;
   assign p0_busy          = w_busy[0];
   assign p1_busy          = w_busy[1];

endmodule
